// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
//
// Parses framed commands arriving byte-by-byte from a UART receiver and
// replays the payload on a valid/ready stream once the frame checksum has
// been verified.
//
//   Frame : SYNC_BYTE, LEN, LEN payload bytes, CHK
//           CHK = (LEN + sum(payload)) mod 256, LEN in 1..MAX_LEN
//
// Parameters
//   MAX_LEN       maximum payload bytes per frame (1..255)
//   SYNC_BYTE     frame start marker
//   TIMEOUT_CLKS  inter-byte timeout in i_Clock cycles (timeout build only)
//
// Build option
//   UART_CMD_PARSER_TIMEOUT_EN  when defined, a frame stalled in LEN,
//                               PAYLOAD or CHK for TIMEOUT_CLKS cycles is
//                               abandoned with error code 11. When undefined
//                               no timeout counter exists and the parser
//                               waits indefinitely mid-frame.
//
// Ports
//   i_Clock       clock, rising edge
//   i_Rst_n       asynchronous reset, active low
//   i_Rx_DV       byte-valid strobe from the UART receiver
//   i_Rx_Byte     received byte, sampled when i_Rx_DV=1
//   o_Data_Valid  payload byte available
//   o_Data        payload byte
//   o_Data_Last   o_Data is the final payload byte of the frame
//   i_Data_Ready  consumer accepts o_Data
//   o_Err         one-cycle error pulse
//   o_Err_Code    00 overrun, 01 bad length, 10 checksum, 11 timeout
//   o_Busy        high whenever the parser is not idle
//
// States
//   S_IDLE    | hunting for SYNC_BYTE, other bytes discarded
//   S_LEN     | waiting for the length byte
//   S_PAYLOAD | storing payload bytes and accumulating the checksum
//   S_CHK     | waiting for the checksum byte
//   S_DRAIN   | presenting buffered payload on o_Data; rx bytes are overruns
// ---------------------------------------------------------------------------
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 10000
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Data_Valid,
  output logic [7:0] o_Data,
  output logic       o_Data_Last,
  input  logic       i_Data_Ready,
  output logic       o_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Busy
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] ERR_OVERRUN = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TMO     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t          state_q;
  logic [7:0]      len_q;
  logic [7:0]      chk_q;
  logic [IW-1:0]   wr_idx_q;
  logic [IW-1:0]   rd_idx_q;
  logic            valid_q;
  logic [7:0]      data_q;
  logic            last_q;
  logic            err_q;
  logic [1:0]      err_code_q;

  logic [7:0]      buf_q [MAX_LEN];

  logic [7:0]      chk_d;
  logic [IW-1:0]   wr_idx_d;
  logic [IW-1:0]   rd_idx_d;
  logic            len_ok;
  logic            wr_last;
  logic            rd_next_last;
  logic            in_frame;
  logic            tmo_hit;

  assign chk_d        = chk_q + i_Rx_Byte;
  assign wr_idx_d     = wr_idx_q + IW'(1);
  assign rd_idx_d     = rd_idx_q + IW'(1);
  assign len_ok       = (i_Rx_Byte != 8'd0) && (32'(i_Rx_Byte) <= MAX_LEN);
  assign wr_last      = (8'(wr_idx_q) == (len_q - 8'd1));
  assign rd_next_last = (8'(rd_idx_d) == (len_q - 8'd1));
  assign in_frame     = (state_q == S_LEN) || (state_q == S_PAYLOAD) ||
                        (state_q == S_CHK);

`ifdef UART_CMD_PARSER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CLKS - 1);

  // Down-counter reloaded on every accepted byte (and while idle); reaching
  // zero with no byte arriving in that same cycle is the expiry. A byte in
  // the expiry cycle wins because the hit term is gated by !i_Rx_DV.
  logic [TW-1:0] tmo_q;

  assign tmo_hit = in_frame && !i_Rx_DV && (tmo_q == '0);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tmo_q <= TMO_LOAD;
    end else if ((state_q == S_IDLE) || i_Rx_DV) begin
      tmo_q <= TMO_LOAD;
    end else if (tmo_q != '0) begin
      tmo_q <= tmo_q - TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Payload storage; deliberately not reset, a reset abandons the frame and
  // the stale contents are never presented.
  always_ff @(posedge i_Clock) begin
    if ((state_q == S_PAYLOAD) && i_Rx_DV) begin
      buf_q[wr_idx_q] <= i_Rx_Byte;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= 8'd0;
      chk_q      <= 8'd0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      valid_q    <= 1'b0;
      data_q     <= 8'd0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      err_q <= 1'b0;
      if (tmo_hit) begin
        state_q    <= S_IDLE;
        err_q      <= 1'b1;
        err_code_q <= ERR_TMO;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
              state_q <= S_LEN;
            end
          end

          S_LEN: begin
            if (i_Rx_DV) begin
              if (len_ok) begin
                len_q    <= i_Rx_Byte;
                chk_q    <= i_Rx_Byte;
                wr_idx_q <= '0;
                state_q  <= S_PAYLOAD;
              end else begin
                // The rejected length byte is not re-examined as a sync byte.
                err_q      <= 1'b1;
                err_code_q <= ERR_LEN;
                state_q    <= S_IDLE;
              end
            end
          end

          S_PAYLOAD: begin
            if (i_Rx_DV) begin
              chk_q <= chk_d;
              if (wr_last) begin
                state_q <= S_CHK;
              end else begin
                wr_idx_q <= wr_idx_d;
              end
            end
          end

          S_CHK: begin
            if (i_Rx_DV) begin
              if (i_Rx_Byte == chk_q) begin
                // First payload byte goes out the cycle after the CHK strobe.
                state_q  <= S_DRAIN;
                rd_idx_q <= '0;
                valid_q  <= 1'b1;
                data_q   <= buf_q[0];
                last_q   <= (len_q == 8'd1);
              end else begin
                err_q      <= 1'b1;
                err_code_q <= ERR_CHK;
                state_q    <= S_IDLE;
              end
            end
          end

          S_DRAIN: begin
            if (i_Rx_DV) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_OVERRUN;
            end
            if (valid_q && i_Data_Ready) begin
              if (last_q) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                rd_idx_q <= rd_idx_d;
                data_q   <= buf_q[rd_idx_d];
                last_q   <= rd_next_last;
              end
            end
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_Data_Valid = valid_q;
  assign o_Data       = data_q;
  assign o_Data_Last  = last_q;
  assign o_Err        = err_q;
  assign o_Err_Code   = err_code_q;
  assign o_Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rdy = 1'b1;
  logic       d_valid;
  logic [7:0] d_data;
  logic       d_last;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .MAX_LEN     (MAX_LEN),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Rx_DV     (rx_dv),
    .i_Rx_Byte   (rx_byte),
    .o_Data_Valid(d_valid),
    .o_Data      (d_data),
    .o_Data_Last (d_last),
    .i_Data_Ready(rdy),
    .o_Err       (err),
    .o_Err_Code  (err_code),
    .o_Busy      (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] got_d[$];
  logic [1:0] got_e[$];
  logic [8:0] exp_d[$];
  logic [1:0] exp_e[$];

  bit   rnd_ready = 1'b0;
  logic ready_val = 1'b1;

  // Ready changes at posedge+2 so the main thread can set ready_val at +1.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Monitor: collects transfers and error pulses, and checks that a stalled
  // beat is held unchanged into the next cycle.
  logic       stall_prev = 1'b0;
  logic [8:0] stall_beat = 9'h0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall_prev) begin
          vectors++;
          if (!d_valid || ({d_last, d_data} != stall_beat)) begin
            miscompares++;
            $display("FAIL hold_stable: got valid=%0d beat=%03h, required valid=1 beat=%03h",
                     d_valid, {d_last, d_data}, stall_beat);
          end
        end
        if (d_valid && rdy) got_d.push_back({d_last, d_data});
        if (err) got_e.push_back(err_code);
        stall_prev = d_valid && !rdy;
        stall_beat = {d_last, d_data};
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_dv   = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (busy && (k < limit)) begin
      tick(1);
      k++;
    end
    check("wait_idle_busy", int'(busy), 0);
  endtask

  task automatic clear_q();
    got_d.delete();
    got_e.delete();
    exp_d.delete();
    exp_e.delete();
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_ndata"}, got_d.size(), exp_d.size());
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++)
      check({tag, "_beat"}, int'(got_d[i]), int'(exp_d[i]));
    check({tag, "_nerr"}, got_e.size(), exp_e.size());
    for (int i = 0; i < got_e.size() && i < exp_e.size(); i++)
      check({tag, "_errcode"}, int'(got_e[i]), int'(exp_e[i]));
    clear_q();
  endtask

  typedef struct {
    string        name;
    int           n;
    logic [191:0] bytes;   // first byte most significant within low n bytes
    int           nd;
    logic [127:0] data;
    int           err;     // -1: none
  } vec_t;

  vec_t tbl[9];

  // Reference model for one frame: expected beats and errors from the
  // frame rules alone.
  task automatic model_frame(input int kind, output logic [7:0] q[$]);
    int len, sum;
    logic [7:0] p;
    q.delete();
    if (kind == 3) begin
      len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
      q.push_back(8'hA5);
      q.push_back(8'(len));
      exp_e.push_back(2'b01);
    end else begin
      len = $urandom_range(1, MAX_LEN);
      sum = len;
      q.push_back(8'hA5);
      q.push_back(8'(len));
      for (int j = 0; j < len; j++) begin
        p = 8'($urandom);
        sum = sum + p;
        q.push_back(p);
        if (kind != 2) exp_d.push_back({(j == len - 1), p});
      end
      if (kind == 2) begin
        q.push_back(8'((sum + $urandom_range(1, 255)) % 256));
        exp_e.push_back(2'b10);
      end else begin
        q.push_back(8'(sum % 256));
      end
    end
  endtask

  initial begin
    logic [7:0] fq[$];
    logic [7:0] nb;
    int nz;

    tbl[0] = '{"basic3", 6, {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 3,
               {8'h11, 8'h22, 8'h33}, -1};
    tbl[1] = '{"badchk", 5, {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00}, 0, 128'h0, 2};
    tbl[2] = '{"len17", 2, {8'hA5, 8'h11}, 0, 128'h0, 1};
    tbl[3] = '{"one", 4, {8'hA5, 8'h01, 8'h7F, 8'h80}, 1, {8'h7F}, -1};
    tbl[4] = '{"len0", 2, {8'hA5, 8'h00}, 0, 128'h0, 1};
    tbl[5] = '{"len_a5", 5, {8'hA5, 8'hA5, 8'h01, 8'h7F, 8'h80}, 0, 128'h0, 1};
    tbl[6] = '{"noise", 7, {8'h00, 8'hFF, 8'hA5, 8'h02, 8'hA5, 8'h5A, 8'h01}, 2,
               {8'hA5, 8'h5A}, -1};
    tbl[7] = '{"max16", 19, {8'hA5, 8'h10, 128'h000102030405060708090A0B0C0D0E0F, 8'h88},
               16, 128'h000102030405060708090A0B0C0D0E0F, -1};
    tbl[8] = '{"chkwrap", 5, {8'hA5, 8'h02, 8'hFF, 8'h02, 8'h03}, 2, {8'hFF, 8'h02}, -1};

    // Reset state
    #12;
    check("rst_valid", int'(d_valid), 0);
    check("rst_data", int'(d_data), 0);
    check("rst_last", int'(d_last), 0);
    check("rst_err", int'(err), 0);
    check("rst_code", int'(err_code), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
    clear_q();

    // Table-driven frames, consumer always ready
    ready_val = 1'b1;
    tick(1);
    foreach (tbl[v]) begin
      for (int i = 0; i < tbl[v].n; i++) send_byte(tbl[v].bytes[8*(tbl[v].n-1-i) +: 8]);
      wait_idle(100);
      tick(2);
      for (int j = 0; j < tbl[v].nd; j++)
        exp_d.push_back({(j == tbl[v].nd - 1), tbl[v].data[8*(tbl[v].nd-1-j) +: 8]});
      if (tbl[v].err >= 0) exp_e.push_back(2'(tbl[v].err));
      check({tbl[v].name, "_busy_after"}, int'(busy), 0);
      compare_q(tbl[v].name);
    end

    // First-valid latency and back-to-back delivery
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    check("lat_valid0", int'(d_valid), 1);
    check("lat_data0", int'(d_data), 'h11);
    check("lat_last0", int'(d_last), 0);
    tick(1);
    check("lat_data1", int'(d_data), 'h22);
    check("lat_last1", int'(d_last), 0);
    tick(1);
    check("lat_data2", int'(d_data), 'h33);
    check("lat_last2", int'(d_last), 1);
    tick(1);
    check("lat_valid_end", int'(d_valid), 0);
    check("lat_busy_end", int'(busy), 0);
    tick(2);
    clear_q();

    // Back-pressure for 5 cycles plus an overrun byte during DRAIN
    ready_val = 1'b0;
    tick(1);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    check("stall_data0", int'(d_data), 'h11);
    send_byte(8'h55);
    check("ovr_err", int'(err), 1);
    check("ovr_code", int'(err_code), 0);
    for (int k = 1; k < 5; k++) begin
      check("stall_valid", int'(d_valid), 1);
      check("stall_data", int'(d_data), 'h11);
      check("stall_last", int'(d_last), 0);
      if (k < 4) tick(1);
    end
    ready_val = 1'b1;
    wait_idle(50);
    tick(2);
    exp_d.push_back({1'b0, 8'h11});
    exp_d.push_back({1'b0, 8'h22});
    exp_d.push_back({1'b1, 8'h33});
    exp_e.push_back(2'b00);
    compare_q("stall");

    // Reset during DRAIN
    ready_val = 1'b0;
    tick(1);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    check("mid_valid", int'(d_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(d_valid), 0);
    check("mid_rst_data", int'(d_data), 0);
    check("mid_rst_last", int'(d_last), 0);
    check("mid_rst_err", int'(err), 0);
    check("mid_rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(3);
    ready_val = 1'b1;
    tick(1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    wait_idle(50);
    tick(2);
    exp_d.push_back({1'b1, 8'h7F});
    compare_q("after_rst");

    // Inter-byte stall mid-frame
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
`ifdef UART_CMD_PARSER_TIMEOUT_EN
    tick(TMO - 1);
    check("tmo_early_err", int'(err), 0);
    check("tmo_early_busy", int'(busy), 1);
    tick(1);
    check("tmo_err", int'(err), 1);
    check("tmo_code", int'(err_code), 3);
    check("tmo_busy", int'(busy), 0);
    tick(2);
    exp_e.push_back(2'b11);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
`else
    tick(TMO + 50);
    check("notmo_busy", int'(busy), 1);
    check("notmo_err", int'(err), 0);
`endif
    send_byte(8'h20); send_byte(8'h32);
    wait_idle(50);
    tick(2);
    exp_d.push_back({1'b0, 8'h10});
    exp_d.push_back({1'b1, 8'h20});
    compare_q("stall_frame");

    // Randomized frames against the reference model
    rnd_ready = 1'b1;
    for (int f = 0; f < 200; f++) begin
      nz = $urandom_range(0, 2);
      for (int i = 0; i < nz; i++) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h3C;
        send_byte(nb);
      end
      model_frame($urandom_range(0, 3), fq);
      foreach (fq[i]) begin
        send_byte(fq[i]);
        tick($urandom_range(0, 3));
      end
      wait_idle(2000);
      tick(2);
      compare_q("rand");
    end
    rnd_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, giving the maximum payload bytes per frame (range 1..255).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, giving the frame start marker.
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 10000, giving the inter-byte timeout in i_Clock cycles.
REQ-004 SHALL have port i_Clock  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port i_Rst_n  input  1  asynchronous reset, active-low.
REQ-006 SHALL have port i_Rx_DV  input  1  one-cycle strobe from the UART receiver: byte valid.
REQ-007 SHALL have port i_Rx_Byte  input  8  received byte, sampled only when i_Rx_DV=1.
REQ-008 SHALL have port o_Data_Valid  output  1  payload byte available.
REQ-009 SHALL have port o_Data  output  8  payload byte.
REQ-010 SHALL have port o_Data_Last  output  1  current o_Data is the final payload byte of the frame.
REQ-011 SHALL have port i_Data_Ready  input  1  consumer accepts o_Data.
REQ-012 SHALL have port o_Err  output  1  one-cycle error pulse.
REQ-013 SHALL have port o_Err_Code  output  2  error cause, valid while o_Err=1: 00 overrun, 01 bad length, 10 checksum, 11 timeout.
REQ-014 SHALL have port o_Busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL accept frames of the form SYNC_BYTE, LEN, LEN payload bytes, CHK, with CHK = (LEN + sum of payload) mod 256.
REQ-016 SHALL implement the states IDLE, LEN, PAYLOAD, CHK and DRAIN, and SHALL consume a byte only in a cycle where i_Rx_DV=1.
REQ-017 In IDLE, on a byte equal to SYNC_BYTE, SHALL go to LEN; SHALL silently discard any other byte.
REQ-018 In LEN, for LEN in 1..MAX_LEN, SHALL store LEN, seed the checksum with LEN and go to PAYLOAD; for LEN=0 or LEN>MAX_LEN, SHALL pulse o_Err with code 01 and go to IDLE, without re-examining that byte as a sync byte.
REQ-019 In PAYLOAD, SHALL write each byte to buffer[index], add it to the 8-bit wrapping checksum, and go to CHK after the LEN-th byte.
REQ-020 In CHK, on a match SHALL go to DRAIN; on a mismatch SHALL pulse o_Err with code 10, go to IDLE, and present no data.
REQ-021 In DRAIN, SHALL assert o_Data_Valid from the cycle after the CHK byte, with o_Data = buffer[0]; this fixes the latency from the CHK strobe to first valid at 1 cycle.
REQ-022 A transfer SHALL occur on o_Data_Valid & i_Data_Ready; on each transfer SHALL advance the read index.
REQ-023 o_Data and o_Data_Last SHALL be held stable while o_Data_Valid=1 and i_Data_Ready=0.
REQ-024 o_Data_Last SHALL equal 1 exactly when the read index = LEN-1; after the last transfer, o_Data_Valid SHALL drop on the next cycle and the state SHALL be IDLE.
REQ-025 An i_Rx_DV in DRAIN SHALL drop its byte and pulse o_Err with code 00; state and output data SHALL be unaffected.
REQ-026 o_Err SHALL be registered and SHALL assert in the cycle after the offending event, for exactly one cycle.
REQ-027 A frame of MAX_LEN bytes SHALL fill the buffer exactly, with no index wrap-around.

Reset
REQ-028 On i_Rst_n=0, SHALL immediately set state=IDLE, o_Data_Valid=0, o_Data=0, o_Data_Last=0, o_Err=0, o_Err_Code=00, o_Busy=0, and clear all counters and indices.
REQ-029 Reset mid-frame or mid-DRAIN SHALL abandon the frame without an error pulse; buffer contents need not be cleared.

Configuration
REQ-030 With macro UART_CMD_PARSER_TIMEOUT_EN defined, SHALL count cycles since the last accepted byte while in LEN, PAYLOAD or CHK; on reaching TIMEOUT_CLKS, SHALL pulse o_Err with code 11 and go to IDLE.
REQ-031 With the macro defined, an i_Rx_DV arriving in the expiry cycle SHALL take priority and reset the counter.
REQ-032 Without the macro, SHALL include no timeout counter, SHALL never produce code 11, and SHALL wait indefinitely mid-frame.

Verification
REQ-033 A5 03 11 22 33 69 with ready=1 -> o_Data 11, 22, 33 on consecutive cycles; Last only on 33; o_Err never asserted.
REQ-034 A5 02 10 20 00 -> o_Err=1 with code 10 once; o_Data_Valid never asserted; o_Busy=0 afterwards.
REQ-035 A5 11 with MAX_LEN=16 -> o_Err with code 01; a following A5 01 7F 80 -> single byte 7F with Last=1.
REQ-036 Good 3-byte frame with ready held low 5 cycles, plus one extra i_Rx_DV during DRAIN -> o_Data=11 stable for all 5 cycles; o_Err with code 00; all 3 bytes then delivered.
REQ-037 With macro defined and TIMEOUT_CLKS=100, A5 02 10 then idle -> o_Err with code 11 100 cycles after the 10 strobe; next good frame accepted.
REQ-038 i_Rst_n pulsed low during DRAIN -> all outputs 0 at once; no o_Err; next frame parsed normally.
